// File: rtl/stack_cmd_sequencer.sv
// Request/response front end for the behavioural stack: one-cycle stack command pulses,
// occupancy tracking and rejection of illegal ops. Optional STACK_SEQ_ERRCNT_EN adds err_count.
module stack_cmd_sequencer #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned IDX_W  = 3,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [IDX_W-1:0]  req_index,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [1:0]        s_command,
  output logic [IDX_W-1:0]  s_index,
  output logic [DATA_W-1:0] s_i_data,
  input  logic [DATA_W-1:0] s_o_data,
  output logic [CNT_W-1:0]  depth_cnt
`ifdef STACK_SEQ_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam logic [1:0] OpNop  = 2'b00;
  localparam logic [1:0] OpPush = 2'b01;
  localparam logic [1:0] OpPop  = 2'b10;
  localparam logic [1:0] OpGet  = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e     state_q;
  logic [1:0] op_q;
  logic       req_illegal;

  assign req_ready = (state_q == StIdle);

  always_comb begin
    req_illegal = 1'b0;
    unique case (req_op)
      OpPush:  req_illegal = (depth_cnt == CNT_W'(DEPTH));
      OpPop:   req_illegal = (depth_cnt == '0);
      OpGet:   req_illegal = (32'(req_index) >= 32'(depth_cnt));
      default: req_illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpNop;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      s_command <= OpNop;
      s_index   <= '0;
      s_i_data  <= '0;
      depth_cnt <= '0;
`ifdef STACK_SEQ_ERRCNT_EN
      err_count <= 8'h00;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q <= req_op;
            if (req_illegal || req_op == OpNop) begin
              // Rejected or NOP: answer directly, the stack never sees it.
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_err   <= req_illegal;
`ifdef STACK_SEQ_ERRCNT_EN
              if (req_illegal && err_count != 8'hFF) err_count <= err_count + 8'h01;
`endif
            end else begin
              state_q   <= StIssue;
              s_command <= req_op;
              s_index   <= req_index;
              s_i_data  <= req_data;
            end
          end
        end
        StIssue: begin
          s_command <= OpNop;
          s_index   <= '0;
          s_i_data  <= '0;
          if (op_q == OpPush) begin
            depth_cnt <= depth_cnt + CNT_W'(1);
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
          end else begin
            if (op_q == OpPop) depth_cnt <= depth_cnt - CNT_W'(1);
            state_q <= StWait;
          end
        end
        StWait: begin
          state_q   <= StResp;
          rsp_valid <= 1'b1;
          rsp_data  <= s_o_data;
          rsp_err   <= 1'b0;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Directed bench for stack_cmd_sequencer; define STACK_SEQ_ERRCNT_EN to also check err_count.
module tb_stack_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [2:0] req_index;
  logic [3:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [1:0] s_command;
  logic [2:0] s_index;
  logic [3:0] s_i_data;
  logic [3:0] s_o_data;
  logic [2:0] depth_cnt;
`ifdef STACK_SEQ_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  stack_cmd_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_index (req_index),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .s_command (s_command),
    .s_index   (s_index),
    .s_i_data  (s_i_data),
    .s_o_data  (s_o_data),
    .depth_cnt (depth_cnt)
`ifdef STACK_SEQ_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one request from a negedge in IDLE; drives odata on s_o_data only during WAIT.
  task automatic run_req(input logic [1:0] op, input logic [2:0] idx, input logic [3:0] data,
                         input logic [3:0] odata, output int lat, output logic [3:0] rdata,
                         output logic rerr, output int ncmd, output logic [1:0] cmd,
                         output logic [2:0] cidx, output logic [3:0] cidata,
                         output logic [2:0] dcnt);
    logic prev_cmd;
    req_op = op; req_index = idx; req_data = data; req_valid = 1'b1;
    lat = 0; ncmd = 0; cmd = 2'b00; cidx = 3'd0; cidata = 4'd0;
    rdata = 4'd0; rerr = 1'b0; dcnt = 3'd0; prev_cmd = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      s_o_data = prev_cmd ? odata : 4'h0;
      prev_cmd = (s_command != 2'b00);
      if (s_command != 2'b00) begin
        ncmd++; cmd = s_command; cidx = s_index; cidata = s_i_data;
      end
      if (rsp_valid) begin
        lat = c; rdata = rsp_data; rerr = rsp_err; dcnt = depth_cnt;
      end
    end
    s_o_data = 4'h0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL run_req_timeout op=%0d got no rsp_valid within 20 cycles", op);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_index = 3'd0; req_data = 4'd0;
    rsp_ready = 1'b1; s_o_data = 4'h0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 4'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    checks++; if (s_command !== 2'b00) begin errors++; $display("FAIL reset_s_command got %b exp 00", s_command); end
    checks++; if (s_index !== 3'd0 || s_i_data !== 4'd0) begin errors++; $display("FAIL reset_s_bus got idx=%0d data=%0d exp 0", s_index, s_i_data); end
    checks++; if (depth_cnt !== 3'd0) begin errors++; $display("FAIL reset_depth got %0d exp 0", depth_cnt); end
`ifdef STACK_SEQ_ERRCNT_EN
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_push_fill();
    int lat, ncmd; logic [3:0] rd, cd; logic re; logic [1:0] cm; logic [2:0] ci, dc;
    for (int i = 1; i <= 5; i++) begin
      run_req(2'b01, 3'd0, 4'(i), 4'h0, lat, rd, re, ncmd, cm, ci, cd, dc);
      checks++; if (lat != 2) begin errors++; $display("FAIL push%0d_latency got %0d exp 2", i, lat); end
      checks++; if (re !== 1'b0 || rd !== 4'h0) begin errors++; $display("FAIL push%0d_rsp got err=%b data=%h exp err=0 data=0", i, re, rd); end
      checks++; if (ncmd != 1 || cm !== 2'b01 || cd !== 4'(i)) begin errors++; $display("FAIL push%0d_cmd got n=%0d cmd=%b idata=%0d exp n=1 cmd=01 idata=%0d", i, ncmd, cm, cd, i); end
      checks++; if (dc !== 3'(i)) begin errors++; $display("FAIL push%0d_depth got %0d exp %0d", i, dc, i); end
    end
  endtask

  task automatic test_overflow();
    int lat, ncmd; logic [3:0] rd, cd; logic re; logic [1:0] cm; logic [2:0] ci, dc;
    run_req(2'b01, 3'd0, 4'd6, 4'h0, lat, rd, re, ncmd, cm, ci, cd, dc);
    checks++; if (lat != 1) begin errors++; $display("FAIL overflow_latency got %0d exp 1", lat); end
    checks++; if (re !== 1'b1 || rd !== 4'h0) begin errors++; $display("FAIL overflow_rsp got err=%b data=%h exp err=1 data=0", re, rd); end
    checks++; if (ncmd != 0) begin errors++; $display("FAIL overflow_no_cmd got %0d cmd cycles exp 0", ncmd); end
    checks++; if (dc !== 3'd5) begin errors++; $display("FAIL overflow_depth got %0d exp 5", dc); end
`ifdef STACK_SEQ_ERRCNT_EN
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL overflow_err_count got %0d exp 1", err_count); end
`endif
  endtask

  task automatic test_get_nop();
    int lat, ncmd; logic [3:0] rd, cd; logic re; logic [1:0] cm; logic [2:0] ci, dc;
    run_req(2'b11, 3'd2, 4'd0, 4'hA, lat, rd, re, ncmd, cm, ci, cd, dc);
    checks++; if (lat != 3) begin errors++; $display("FAIL get2_latency got %0d exp 3", lat); end
    checks++; if (rd !== 4'hA || re !== 1'b0) begin errors++; $display("FAIL get2_rsp got data=%h err=%b exp data=a err=0", rd, re); end
    checks++; if (ncmd != 1 || cm !== 2'b11 || ci !== 3'd2) begin errors++; $display("FAIL get2_cmd got n=%0d cmd=%b idx=%0d exp n=1 cmd=11 idx=2", ncmd, cm, ci); end
    checks++; if (dc !== 3'd5) begin errors++; $display("FAIL get2_depth got %0d exp 5", dc); end
    run_req(2'b11, 3'd4, 4'd0, 4'h3, lat, rd, re, ncmd, cm, ci, cd, dc);
    checks++; if (re !== 1'b0 || rd !== 4'h3 || ci !== 3'd4) begin errors++; $display("FAIL get4_rsp got err=%b data=%h idx=%0d exp err=0 data=3 idx=4", re, rd, ci); end
    run_req(2'b11, 3'd5, 4'd0, 4'hA, lat, rd, re, ncmd, cm, ci, cd, dc);
    checks++; if (lat != 1 || re !== 1'b1 || rd !== 4'h0) begin errors++; $display("FAIL get5_rsp got lat=%0d err=%b data=%h exp lat=1 err=1 data=0", lat, re, rd); end
    checks++; if (ncmd != 0) begin errors++; $display("FAIL get5_no_cmd got %0d cmd cycles exp 0", ncmd); end
`ifdef STACK_SEQ_ERRCNT_EN
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL get5_err_count got %0d exp 2", err_count); end
`endif
    run_req(2'b00, 3'd0, 4'd9, 4'h0, lat, rd, re, ncmd, cm, ci, cd, dc);
    checks++; if (lat != 1 || re !== 1'b0 || ncmd != 0 || dc !== 3'd5) begin errors++; $display("FAIL nop_rsp got lat=%0d err=%b ncmd=%0d depth=%0d exp 1 0 0 5", lat, re, ncmd, dc); end
  endtask

  task automatic test_pop_drain();
    int lat, ncmd; logic [3:0] rd, cd; logic re; logic [1:0] cm; logic [2:0] ci, dc;
    for (int i = 0; i < 5; i++) begin
      run_req(2'b10, 3'd0, 4'd0, 4'(5 - i), lat, rd, re, ncmd, cm, ci, cd, dc);
      checks++; if (lat != 3 || re !== 1'b0) begin errors++; $display("FAIL pop%0d_rsp got lat=%0d err=%b exp lat=3 err=0", i, lat, re); end
      checks++; if (rd !== 4'(5 - i)) begin errors++; $display("FAIL pop%0d_data got %0d exp %0d", i, rd, 5 - i); end
      checks++; if (ncmd != 1 || cm !== 2'b10) begin errors++; $display("FAIL pop%0d_cmd got n=%0d cmd=%b exp n=1 cmd=10", i, ncmd, cm); end
      checks++; if (dc !== 3'(4 - i)) begin errors++; $display("FAIL pop%0d_depth got %0d exp %0d", i, dc, 4 - i); end
    end
    run_req(2'b10, 3'd0, 4'd0, 4'hF, lat, rd, re, ncmd, cm, ci, cd, dc);
    checks++; if (lat != 1 || re !== 1'b1 || ncmd != 0 || dc !== 3'd0) begin errors++; $display("FAIL underflow got lat=%0d err=%b ncmd=%0d depth=%0d exp 1 1 0 0", lat, re, ncmd, dc); end
`ifdef STACK_SEQ_ERRCNT_EN
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL underflow_err_count got %0d exp 3", err_count); end
`endif
  endtask

  task automatic test_backpressure();
    int lat, ncmd, waited; logic [3:0] rd, cd; logic re; logic [1:0] cm; logic [2:0] ci, dc;
    rsp_ready = 1'b0;
    req_op = 2'b01; req_data = 4'd9; req_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk); req_valid = 1'b0; waited++;
    end while (!rsp_valid && waited < 10);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout got rsp_valid=%b exp 1", rsp_valid); end
    for (int i = 0; i < 3; i++) begin
      req_op = 2'b10; req_valid = (i != 1);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 4'h0) begin errors++; $display("FAIL bp_hold%0d got v=%b err=%b data=%h exp 1 0 0", i, rsp_valid, rsp_err, rsp_data); end
      checks++; if (req_ready !== 1'b0 || s_command !== 2'b00) begin errors++; $display("FAIL bp_blocked%0d got ready=%b cmd=%b exp 0 00", i, req_ready, s_command); end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || depth_cnt !== 3'd1) begin errors++; $display("FAIL bp_release got v=%b ready=%b depth=%0d exp 0 1 1", rsp_valid, req_ready, depth_cnt); end
    run_req(2'b10, 3'd0, 4'd0, 4'h9, lat, rd, re, ncmd, cm, ci, cd, dc);
    checks++; if (lat != 3 || re !== 1'b0 || rd !== 4'h9 || dc !== 3'd0) begin errors++; $display("FAIL bp_after_pop got lat=%0d err=%b data=%h depth=%0d exp 3 0 9 0", lat, re, rd, dc); end
  endtask

  task automatic test_reset_mid();
    int lat, ncmd; logic [3:0] rd, cd; logic re; logic [1:0] cm; logic [2:0] ci, dc;
    run_req(2'b01, 3'd0, 4'd3, 4'h0, lat, rd, re, ncmd, cm, ci, cd, dc);
    req_op = 2'b10; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    checks++; if (s_command !== 2'b10) begin errors++; $display("FAIL mid_issue_cmd got %b exp 10", s_command); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (s_command !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out got cmd=%b v=%b exp 00 0", s_command, rsp_valid); end
    checks++; if (depth_cnt !== 3'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_state got depth=%0d ready=%b exp 0 1", depth_cnt, req_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_discard got rsp_valid=%b exp 0", rsp_valid); end
    run_req(2'b01, 3'd0, 4'd7, 4'h0, lat, rd, re, ncmd, cm, ci, cd, dc);
    checks++; if (lat != 2 || re !== 1'b0 || cd !== 4'd7 || dc !== 3'd1) begin errors++; $display("FAIL mid_push7 got lat=%0d err=%b idata=%0d depth=%0d exp 2 0 7 1", lat, re, cd, dc); end
  endtask

  initial begin
    test_reset();
    test_push_fill();
    test_overflow();
    test_get_nop();
    test_pop_drain();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
